// File: rtl/key_encoder_83_if.sv
// Key encoder bus: keypad/enable inputs toward the encoder and the
// encoded key outputs back to whoever consumes them.
interface key_encoder_83_if;
  logic [2:0] enable;
  logic [7:0] key_n;
  logic [2:0] code;
  logic       code_valid;
  logic       key_held;
  logic       multi;

  // Driver side: controls enable and key lines, observes the encoded key.
  modport master (
    output enable,
    output key_n,
    input  code,
    input  code_valid,
    input  key_held,
    input  multi
  );

  // Encoder side.
  modport slave (
    input  enable,
    input  key_n,
    output code,
    output code_valid,
    output key_held,
    output multi
  );
endinterface

// File: rtl/key_encoder_83.sv
// 8-to-3 debounced key encoder.
// The key lines are synchronized first.  A press is accepted once the
// synchronized pattern has been identical for DEBOUNCE_CYCLES cycles.  On
// acceptance, the lowest pressed index is reported with a one-cycle
// code_valid pulse.  key_held stays high until an all-released pattern has
// been stable for DEBOUNCE_CYCLES cycles.  DEBOUNCE_CYCLES must lie in
// 2..65535 so that the 16-bit counter can reach its terminal count.
module key_encoder_83 #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  key_encoder_83_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_e;

  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  ALL_UP   = 8'hFF;

  state_e      state_q, state_d;
  logic [7:0]  key_meta, key_s;
  logic [7:0]  snap_q, snap_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0]  code_q, code_d;
  logic        multi_q, multi_d;
  logic        valid_q, valid_d;
  logic        held_q, held_d;
  logic        enabled;

  // Lowest index with a low (pressed) bit; 0 when no bit is low.
  function automatic logic [2:0] lowest_zero(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!v[i]) r = 3'(i);
    end
    return r;
  endfunction

  assign enabled = (bus.enable == 3'b100);

  // The counter saturates instead of wrapping.
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  // Two-flop synchronizer for the asynchronous key lines; resets to "no key".
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_meta <= ALL_UP;
      key_s    <= ALL_UP;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the pre-edge
      // values, so this forms a two-stage shift chain rather than a wire.
      key_meta <= bus.key_n;
      key_s    <= key_meta;
    end
  end

  // Next-state and datapath decode for the debounce FSM.
  always_comb begin
    // NOTE: every signal assigned here gets a default first.  This prevents
    // paths that leave a signal unassigned from inferring a latch.
    state_d = state_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    multi_d = multi_q;
    valid_d = 1'b0;
    held_d  = held_q;

    if (!enabled) begin
      // Disable wins over every other transition; code/multi keep their values.
      state_d = IDLE;
      cnt_d   = '0;
      held_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          held_d = 1'b0;
          if (key_s != ALL_UP) begin
            state_d = DEBOUNCE;
            snap_d  = key_s;
            cnt_d   = '0;
          end
        end
        DEBOUNCE: begin
          if (key_s != snap_q) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = PRESSED;
            cnt_d   = '0;
            code_d  = lowest_zero(snap_q);
            multi_d = ($countones(~snap_q) > 1);
            valid_d = 1'b1;
            held_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        PRESSED: begin
          held_d = 1'b1;
          if (key_s == ALL_UP) begin
            state_d = RELEASE;
            cnt_d   = '0;
          end
        end
        RELEASE: begin
          if (key_s != ALL_UP) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            held_d  = 1'b0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          held_d  = 1'b0;
        end
      endcase
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the snapshot is a plain register rather than a memory.  It is
      // reset to "no key" so that an aborted press leaves no stale pattern.
      state_q <= IDLE;
      snap_q  <= ALL_UP;
      cnt_q   <= '0;
      code_q  <= 3'd0;
      multi_q <= 1'b0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      multi_q <= multi_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  assign bus.code       = code_q;
  assign bus.multi      = multi_q;
  assign bus.code_valid = valid_q;
  assign bus.key_held   = held_q;

endmodule

// File: tb/tb_key_encoder_83.sv
// Bench for key_encoder_83 with DEBOUNCE_CYCLES = 4.
// A table of single-press vectors is followed by directed bounce, release,
// disable and reset sequences, and then randomized stimulus.  Every output
// is checked each cycle against a sample-window reference model.
module tb_key_encoder_83;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  key_encoder_83_if bus ();

  key_encoder_83 #(.DEBOUNCE_CYCLES(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state.  It works on windows of synchronized samples
  // identified by edge index, rather than on an FSM with a counter.
  logic [7:0] d1, d2;
  int         edge_n = 0;
  bit         held, in_win, in_rel;
  int         win_start, rel_start;
  logic [7:0] win_val;
  logic [2:0] m_code;
  logic       m_multi, m_pulse;

  typedef struct {
    logic [7:0] kn;
    logic [2:0] code;
    logic       multi;
  } vec_t;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    d1 = 8'hFF; d2 = 8'hFF;
    held = 0; in_win = 0; in_rel = 0;
    m_code = 3'd0; m_multi = 1'b0; m_pulse = 1'b0;
  endtask

  function automatic logic [2:0] first_pressed(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (!v[i]) return 3'(i);
    return 3'd0;
  endfunction

  // One rising edge of the reference model.
  task automatic model_edge(input logic [7:0] kn, input logic [2:0] en);
    logic [7:0] ks;
    ks = d2; d2 = d1; d1 = kn;
    m_pulse = 1'b0;
    if (en != 3'b100) begin
      held = 0; in_win = 0; in_rel = 0;
    end else if (!held) begin
      if (!in_win) begin
        if (ks != 8'hFF) begin in_win = 1; win_start = edge_n; win_val = ks; end
      end else if (ks != win_val) begin
        in_win = 0;
      end else if (edge_n - win_start == D) begin
        m_code  = first_pressed(win_val);
        m_multi = ($countones(~win_val) >= 2);
        m_pulse = 1'b1;
        held = 1; in_win = 0; in_rel = 0;
      end
    end else begin
      if (!in_rel) begin
        if (ks == 8'hFF) begin in_rel = 1; rel_start = edge_n; end
      end else if (ks != 8'hFF) begin
        in_rel = 0;
      end else if (edge_n - rel_start == D) begin
        held = 0; in_rel = 0;
      end
    end
    edge_n++;
  endtask

  function automatic logic [7:0] outs();
    return {2'b00, bus.code, bus.multi, bus.code_valid, bus.key_held};
  endfunction

  // Apply inputs, clock once, and compare all outputs with the model.
  task automatic step(input logic [7:0] kn, input logic [2:0] en);
    bus.key_n  = kn;
    bus.enable = en;
    @(posedge clk);
    model_edge(kn, en);
    #1;
    check("model", outs(), {2'b00, m_code, m_multi, m_pulse, held});
  endtask

  task automatic idle_out();
    repeat (D + 6) step(8'hFF, 3'b100);
  endtask

  vec_t tbl[7];
  int   pulses, pulse_at;

  initial begin
    tbl[0] = '{8'hF7, 3'd3, 1'b0};
    tbl[1] = '{8'hDB, 3'd2, 1'b1};
    tbl[2] = '{8'hFE, 3'd0, 1'b0};
    tbl[3] = '{8'h7F, 3'd7, 1'b0};
    tbl[4] = '{8'h00, 3'd0, 1'b1};
    tbl[5] = '{8'hBF, 3'd6, 1'b0};
    tbl[6] = '{8'h3F, 3'd6, 1'b1};

    bus.enable = 3'b100;
    bus.key_n  = 8'hFF;
    model_reset();
    #1;
    check("reset_state", outs(), 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Single clean presses: one pulse at edge D+2, expected code/multi.
    foreach (tbl[t]) begin
      idle_out();
      pulses = 0; pulse_at = -1;
      for (int i = 0; i < 12; i++) begin
        step(tbl[t].kn, 3'b100);
        if (bus.code_valid) begin
          pulses++;
          if (pulse_at < 0) pulse_at = i;
        end
      end
      check("press_pulses", 8'(pulses), 8'd1);
      check("press_latency", 8'(pulse_at), 8'(D + 2));
      check("press_code", {5'b0, bus.code}, {5'b0, tbl[t].code});
      check("press_multi", {7'b0, bus.multi}, {7'b0, tbl[t].multi});
      check("press_held", {7'b0, bus.key_held}, 8'd1);
    end

    // Press too short: no pulse, code keeps the previous value.
    idle_out();
    pulses = 0;
    repeat (3) begin step(8'hF7, 3'b100); pulses += int'(bus.code_valid); end
    repeat (8) begin step(8'hFF, 3'b100); pulses += int'(bus.code_valid); end
    check("bounce_pulses", 8'(pulses), 8'd0);
    check("bounce_code", {5'b0, bus.code}, {5'b0, tbl[6].code});

    // Release that bounces: held stays up, then falls D+2 steps after stable.
    repeat (D + 6) step(8'hFE, 3'b100);
    pulses = 0;
    repeat (2) begin step(8'hFF, 3'b100); check("rel_bounce_held", {7'b0, bus.key_held}, 8'd1); end
    repeat (2) begin step(8'hFE, 3'b100); check("rel_bounce_held", {7'b0, bus.key_held}, 8'd1); end
    for (int j = 0; j < D + 6; j++) begin
      step(8'hFF, 3'b100);
      pulses += int'(bus.code_valid);
      check("rel_held", {7'b0, bus.key_held}, {7'b0, (j < D + 2)});
    end
    check("rel_pulses", 8'(pulses), 8'd0);

    // Disable while pressed, then re-enable with the key still down.
    repeat (D + 6) step(8'hF7, 3'b100);
    step(8'hF7, 3'b000);
    check("dis_held", {7'b0, bus.key_held}, 8'd0);
    check("dis_code", {5'b0, bus.code}, 8'd3);
    repeat (3) step(8'hF7, 3'b000);
    pulses = 0; pulse_at = -1;
    for (int i = 0; i < 12; i++) begin
      step(8'hF7, 3'b100);
      if (bus.code_valid) begin pulses++; if (pulse_at < 0) pulse_at = i; end
    end
    check("reen_pulses", 8'(pulses), 8'd1);
    check("reen_latency", 8'(pulse_at), 8'(D));

    // Reset in the middle of a debounce.
    idle_out();
    repeat (3) step(8'h7F, 3'b100);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("midreset_outs", outs(), 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    pulses = 0; pulse_at = -1;
    for (int i = 0; i < 12; i++) begin
      step(8'h7F, 3'b100);
      if (bus.code_valid) begin pulses++; if (pulse_at < 0) pulse_at = i; end
    end
    check("postreset_pulses", 8'(pulses), 8'd1);
    check("postreset_latency", 8'(pulse_at), 8'(D + 2));

    // Random key patterns and enables, held for random lengths.
    for (int n = 0; n < 150; n++) begin
      logic [7:0] v;
      logic [2:0] en;
      int         len;
      case ($urandom_range(0, 3))
        0:       v = 8'hFF;
        1:       v = ~(8'h01 << $urandom_range(0, 7));
        default: v = 8'($urandom);
      endcase
      en  = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b100;
      len = $urandom_range(1, 2 * D + 2);
      repeat (len) step(v, en);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/key_encoder_83.md
KEY_ENCODER_83 -- requirements
Module: key_encoder_83

Interface
REQ-001: Parameter DEBOUNCE_CYCLES, default 4, is the number of consecutive stable cycles required to accept a press or release; legal range 2..65535.
REQ-002: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003: rst  input  1  asynchronous, active-low reset; low forces reset state immediately, release is synchronous to clk.
REQ-004: enable  input  3  block is active only when enable == 3'b100; any other value disables it.
REQ-005: key_n  input  8  active-low key/switch lines, asynchronous to clk; bit i low means key i pressed.
REQ-006: code  output  3  binary index of the accepted key; registered.
REQ-007: code_valid  output  1  one-cycle pulse marking a newly accepted press.
REQ-008: key_held  output  1  high while an accepted press has not yet been debounced as released.
REQ-009: multi  output  1  high when more than one key was low in the accepted snapshot; registered and updated with code.

Function
REQ-010: key_n SHALL pass through a 2-flop synchronizer; all other logic uses only the synchronized value (key_s).
REQ-011: The FSM SHALL have exactly four states: IDLE, DEBOUNCE, PRESSED, RELEASE.
REQ-012: IDLE: if enabled and key_s != 8'hFF, go to DEBOUNCE, capture key_s into snapshot, clear counter; otherwise stay.
REQ-013: DEBOUNCE: if key_s != snapshot, return to IDLE with no output change; otherwise increment counter.
REQ-014: DEBOUNCE: when counter == DEBOUNCE_CYCLES-1 and key_s == snapshot, go to PRESSED; in the same edge load code and multi, and assert code_valid for exactly the next cycle.
REQ-015: Encoding priority: code SHALL be the lowest index i with snapshot[i] == 0 (key_n[0] -> 3'd0 ... key_n[7] -> 3'd7).
REQ-016: multi SHALL be 1 iff two or more snapshot bits are 0.
REQ-017: PRESSED: key_held = 1; when key_s == 8'hFF, go to RELEASE and clear counter; key changes while any key remains low SHALL be ignored (no new pulse).
REQ-018: RELEASE: key_held stays 1; if any key_s bit is 0, return to PRESSED (no pulse); otherwise increment counter; at counter == DEBOUNCE_CYCLES-1, go to IDLE and drop key_held.
REQ-019: Latency: when key_n is first sampled low at edge 0 and stays stable, code_valid SHALL be high between edges DEBOUNCE_CYCLES+2 and DEBOUNCE_CYCLES+3.
REQ-020: Counter width SHALL be 16 bits and SHALL never wrap; it is cleared on every state entry.
REQ-021: enable != 3'b100 in any state SHALL force IDLE at the next edge, clear key_held, suppress code_valid; code and multi hold their last values.
REQ-022: code_valid SHALL never be high on two consecutive cycles and SHALL only pulse on the DEBOUNCE->PRESSED transition.
REQ-023: Disable has priority over every other transition when occurring in the same cycle.

Reset
REQ-024: During rst low: state IDLE, synchronizer flops 8'hFF, snapshot 8'hFF, counter 0, code 3'd0, code_valid 0, key_held 0, multi 0.
REQ-025: rst asserted mid-press SHALL abort immediately; after release, a still-held key SHALL be re-debounced and produce one new pulse.

Verification (DEBOUNCE_CYCLES = 4)
REQ-026: enable=3'b100, key_n 8'hFF -> 8'hF7 held -> code_valid pulse at edge 6, code=3'd3, multi=0, key_held=1.
REQ-027: key_n 8'hDB (keys 2 and 5) held -> code=3'd2, multi=1, one pulse only.
REQ-028: key_n low for 3 cycles, then bounces to 8'hFF -> no code_valid, code unchanged, state returns to IDLE.
REQ-029: press accepted, release with 2-cycle bounce back low, then stable 8'hFF -> key_held stays 1 through bounce, falls 4 cycles after final stable release, no extra pulse.
REQ-030: enable switched to 3'b000 while PRESSED -> key_held 0 next edge, code retained; re-enable with key still low -> exactly one new pulse after full debounce.
REQ-031: rst pulsed low mid-DEBOUNCE -> all outputs reset immediately; no pulse until a full debounce completes after reset release.
